// File: rtl/alu_result_buffer.sv
// Two-entry result FIFO between the ALU and writeback, with operand forwarding.
// Define ALU_RESULT_BUF_OVF_CNT_EN to build the saturating overflow-flag counter.
module alu_result_buffer #(
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_result,
  input  logic            in_carry,
  input  logic            in_over,
  input  logic            in_zero,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic            out_carry,
  output logic            out_over,
  output logic            out_zero,
  output logic [RD_W-1:0] out_rd,
  input  logic [RD_W-1:0] fwd_rs,
  output logic            fwd_hit,
  output logic [31:0]     fwd_data,
  input  logic            ovf_clr,
  output logic [15:0]     ovf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]     result;
    logic            carry;
    logic            over;
    logic            zero;
    logic [RD_W-1:0] rd;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   push, pop;
  logic   hit_head, hit_tail;
  logic   rs_nonzero;

  assign in_entry  = '{result: in_result, carry: in_carry, over: in_over,
                       zero: in_zero, rd: in_rd};
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            tail_d  = in_entry;
            state_d = FULL;
          end
          2'b01: begin
            head_d  = '0;
            state_d = EMPTY;
          end
          2'b11: head_d = in_entry;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: the two entries are plain flops, so they take the async reset too; a RAM-style array would not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_result = out_valid ? head_q.result : '0;
  assign out_carry  = out_valid ? head_q.carry  : 1'b0;
  assign out_over   = out_valid ? head_q.over   : 1'b0;
  assign out_zero   = out_valid ? head_q.zero   : 1'b0;
  assign out_rd     = out_valid ? head_q.rd     : '0;

  // The tail is always the younger entry, so it takes priority on a double match.
  assign rs_nonzero = (fwd_rs != '0);
  assign hit_head   = out_valid && rs_nonzero && (head_q.rd == fwd_rs);
  assign hit_tail   = (state_q == FULL) && rs_nonzero && (tail_q.rd == fwd_rs);
  assign fwd_hit    = hit_head || hit_tail;
  assign fwd_data   = hit_tail ? tail_q.result :
                      hit_head ? head_q.result : '0;

`ifdef ALU_RESULT_BUF_OVF_CNT_EN
  logic [15:0] ovf_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count_q <= '0;
    end else if (ovf_clr) begin
      ovf_count_q <= '0;
    end else if (push && in_over && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_q <= ovf_count_q + 16'd1;
    end
  end

  assign ovf_count = ovf_count_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf_count      = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: driver records accepted pushes, a
// negedge monitor checks the head, flow control, forwarding and counter.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry, in_over, in_zero;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry, out_over, out_zero;
  logic [4:0]  out_rd;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        ovf_clr;
  logic [15:0] ovf_count;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic [4:0]  rd;
  } ent_t;

  ent_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  logic        model_ready = 1'b1;
  logic [15:0] model_ovf   = '0;

  alu_result_buffer #(.RD_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_over(in_over), .in_zero(in_zero), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_over(out_over), .out_zero(out_zero), .out_rd(out_rd),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sb holds exactly what the buffer should contain after the last edge.
  always @(negedge clk) begin
    logic        exp_hit;
    logic [31:0] exp_fd;
    if (reset_n) begin
      exp_hit = 1'b0;
      exp_fd  = '0;
      if (fwd_rs != 5'd0)
        foreach (sb[i]) if (sb[i].rd == fwd_rs) begin
          exp_hit = 1'b1;
          exp_fd  = sb[i].res;
        end
      check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
      check("in_ready",  {31'd0, in_ready},  {31'd0, sb.size() < 2});
      if (sb.size() > 0) begin
        check("out_result", out_result, sb[0].res);
        check("out_flags", {29'd0, out_carry, out_over, out_zero}, {29'd0, sb[0].c, sb[0].o, sb[0].z});
        check("out_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
      end else begin
        check("idle_out_zero", out_result | {27'd0, out_rd} | {29'd0, out_carry, out_over, out_zero}, 32'd0);
      end
      check("fwd_hit",  {31'd0, fwd_hit}, {31'd0, exp_hit});
      check("fwd_data", fwd_data, exp_fd);
      check("ovf_count", {16'd0, ovf_count}, {16'd0, model_ovf});
      model_ready = (sb.size() < 2);
      if (out_ready && sb.size() > 0) void'(sb.pop_front());
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic ov,
                     input logic ordy, input logic [4:0] rs, input logic clr);
    ent_t e;
    in_valid = v; in_result = d; in_rd = rd; in_over = ov;
    in_carry = d[0]; in_zero = (d == 32'd0);
    out_ready = ordy; fwd_rs = rs; ovf_clr = clr;
    @(negedge clk); #1;
`ifdef ALU_RESULT_BUF_OVF_CNT_EN
    if (clr) model_ovf = '0;
    else if (v && model_ready && ov && model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
`endif
    if (v && model_ready) begin
      e = '{res: d, c: d[0], o: ov, z: (d == 32'd0), rd: rd};
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy, input logic [4:0] rs);
    cyc(1'b0, 32'd0, 5'd0, 1'b0, ordy, rs, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 0; in_result = 0; in_carry = 0; in_over = 0; in_zero = 0;
    in_rd = 0; out_ready = 0; fwd_rs = 0; ovf_clr = 0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_ovf_count", {16'd0, ovf_count}, 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single push, head visible next cycle, forwarding on rd 3.
    cyc(1'b1, 32'h7, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(1'b0, 5'd3);
    // Fill, offer a third (dropped), drain in order.
    cyc(1'b1, 32'h9, 5'd4, 1'b0, 1'b0, 5'd4, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    idle(1'b1, 5'd0);
    idle(1'b1, 5'd0);
    idle(1'b0, 5'd5);
    // Simultaneous push/pop in ONE.
    cyc(1'b1, 32'h1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 32'h2, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0);
    idle(1'b0, 5'd5);
    idle(1'b1, 5'd0);
    // Youngest match wins; rs 0 never hits.
    cyc(1'b1, 32'h1, 5'd6, 1'b0, 1'b0, 5'd6, 1'b0);
    cyc(1'b1, 32'h8, 5'd6, 1'b0, 1'b0, 5'd6, 1'b0);
    idle(1'b0, 5'd6);
    check("fwd_young_data", fwd_data, 32'h8);
    idle(1'b1, 5'd6);
    idle(1'b1, 5'd0);
    cyc(1'b1, 32'h5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(1'b0, 5'd0);
    check("fwd_rs0_hit", {31'd0, fwd_hit}, 32'd0);
    idle(1'b1, 5'd0);
    // Reset asserted mid-cycle while FULL.
    cyc(1'b1, 32'hA, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 32'hB, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(1'b0, 5'd0);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready",   {31'd0, in_ready},  32'd1);
    check("midrst_out_result", out_result, 32'd0);
    check("midrst_ovf_count",  {16'd0, ovf_count}, 32'd0);
    sb.delete();
    model_ovf   = '0;
    model_ready = 1'b1;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    // Overflow counter: three overflowing pushes, one clean, then clear vs increment.
    cyc(1'b1, 32'h10, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    cyc(1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    cyc(1'b1, 32'h12, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    cyc(1'b1, 32'h13, 5'd1, 1'b0, 1'b1, 5'd0, 1'b0);
    idle(1'b1, 5'd0);
`ifdef ALU_RESULT_BUF_OVF_CNT_EN
    check("ovf_three", {16'd0, ovf_count}, 32'd3);
`else
    check("ovf_tied", {16'd0, ovf_count}, 32'd0);
`endif
    cyc(1'b1, 32'h14, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1);
    idle(1'b1, 5'd0);
    check("ovf_clr_wins", {16'd0, ovf_count}, 32'd0);

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 15) == 0));
    end
    idle(1'b1, 5'd0);
    idle(1'b1, 5'd0);
    idle(1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
